// File: rtl/serial_subtractor_32b_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default
// width and the elaboration-time check on the bits-per-cycle parameter.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

    localparam int DEFAULT_WIDTH = 32;

    // BPC must be a power of two no larger than 8 and must divide the width.
    function automatic bit bpc_legal(input int width, input int bpc);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8)) &&
               ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/serial_subtractor_32b_full_sub.sv
// One full-subtractor cell: computes x + ~y + cin, so that a chain of them
// seeded with cin=1 forms a two's-complement subtract.
module full_sub_1b (
    input  logic x_i,
    input  logic y_i,
    input  logic cin_i,
    output logic d_o,
    output logic cout_o
);

    logic ny;

    assign ny     = ~y_i;
    assign d_o    = x_i ^ ny ^ cin_i;
    assign cout_o = (x_i & ny) | (cin_i & (x_i ^ ny));

endmodule

// File: rtl/serial_subtractor_32b.sv
// Multi-cycle subtractor: diff = a - b, BPC bits per clock LSB first, with a
// self-check flag comparing the serial result against a behavioural subtract.
module serial_subtractor_32b
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             sig,
    output logic [1:0]       dbg_state
);

    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = $clog2(STEPS + 1);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] RUN  = 2'(ST_RUN);
    localparam logic [1:0] DONE = 2'(ST_DONE);

    if (!bpc_legal(WIDTH, BPC)) begin : g_bad_bpc
        $error("serial_subtractor_32b: BPC must be 1, 2, 4 or 8 and divide WIDTH");
    end

    // Handshake: start is sampled only in IDLE or DONE; busy is high for the
    // STEPS cycles of RUN; done pulses for one cycle and results then hold
    // until the next accepted start.
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] a_lat_q, a_lat_d;
    logic [WIDTH-1:0] b_lat_q, b_lat_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;
    logic             sig_q, sig_d;

    logic [BPC:0]     c_chain;
    logic [BPC-1:0]   res;
    logic [WIDTH-1:0] diff_next;

    assign c_chain[0] = carry_q;

    for (genvar gi = 0; gi < BPC; gi++) begin : g_cell
        full_sub_1b u_cell (
            .x_i    (a_sh_q[gi]),
            .y_i    (b_sh_q[gi]),
            .cin_i  (c_chain[gi]),
            .d_o    (res[gi]),
            .cout_o (c_chain[gi+1])
        );
    end

    // Result bits enter from the MSB end so the first slice ends up at the LSB.
    assign diff_next = {res, diff_q[WIDTH-1:BPC]};

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        a_lat_d    = a_lat_q;
        b_lat_d    = b_lat_q;
        diff_d     = diff_q;
        count_d    = count_q;
        carry_d    = carry_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        sig_d      = sig_q;

        case (state_q)
            RUN: begin
                a_sh_d  = a_sh_q >> BPC;
                b_sh_d  = b_sh_q >> BPC;
                diff_d  = diff_next;
                carry_d = c_chain[BPC];
                count_d = count_q + 1'b1;
                if (count_q == CW'(STEPS - 1)) begin
                    state_d    = DONE;
                    borrow_d   = ~c_chain[BPC];
                    overflow_d = (a_lat_q[WIDTH-1] != b_lat_q[WIDTH-1]) &&
                                 (diff_next[WIDTH-1] != a_lat_q[WIDTH-1]);
                    sig_d      = (diff_next == (a_lat_q - b_lat_q));
                end
            end
            default: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    a_lat_d = a;
                    b_lat_d = b;
                    carry_d = 1'b1;
                    count_d = '0;
                    diff_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            a_lat_q    <= '0;
            b_lat_q    <= '0;
            diff_q     <= '0;
            count_q    <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            sig_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            a_lat_q    <= a_lat_d;
            b_lat_q    <= b_lat_d;
            diff_q     <= diff_d;
            count_q    <= count_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            sig_q      <= sig_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;
    assign sig       = sig_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor_32b.sv
// Bench for serial_subtractor_32b: a BPC=1 instance driven by a vector table
// and corner sequences, and a BPC=4 instance for the wide-slice cases.
module tb_serial_subtractor_32b;

  logic        clk;
  logic        rst_n;
  logic        start1, start4;
  logic [31:0] a1, b1, a4, b4;
  logic        busy1, done1, borrow1, ovf1, sig1;
  logic        busy4, done4, borrow4, ovf4, sig4;
  logic [31:0] diff1, diff4;
  logic [1:0]  st1, st4;

  int tests_run;
  int tests_failed;
  int sel;

  serial_subtractor_32b #(.WIDTH(32), .BPC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1),
    .overflow(ovf1), .sig(sig1), .dbg_state(st1)
  );

  serial_subtractor_32b #(.WIDTH(32), .BPC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4),
    .overflow(ovf4), .sig(sig4), .dbg_state(st4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_diff;
    logic        exp_borrow;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic s_done();
    return (sel == 4) ? done4 : done1;
  endfunction

  function automatic logic s_busy();
    return (sel == 4) ? busy4 : busy1;
  endfunction

  // driver: one-cycle start pulse, then count cycles until done (bounded)
  task automatic run_op(input int which, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    sel = which;
    @(negedge clk);
    if (which == 4) begin a4 = a; b4 = b; start4 = 1'b1; end
    else            begin a1 = a; b1 = b; start1 = 1'b1; end
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!s_done() && lat < 100) begin
      if (s_busy()) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bc;
    logic [31:0] ra, rb;

    tests_run = 0;
    tests_failed = 0;
    sel = 1;
    start1 = 0; start4 = 0;
    a1 = 0; b1 = 0; a4 = 0; b4 = 0;

    vecs[0] = '{32'd10,        32'd3,         32'd7,         1'b0, 1'b0};
    vecs[1] = '{32'd3,         32'd10,        32'hFFFF_FFF9, 1'b1, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
    vecs[4] = '{32'd0,         32'd0,         32'd0,         1'b0, 1'b0};
    vecs[5] = '{32'd0,         32'd1,         32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h1111_1111, 32'h0123_4567, 1'b0, 1'b0};
    vecs[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy",  {31'd0, busy1}, 32'd0);
    chk("reset_done",  {31'd0, done1}, 32'd0);
    chk("reset_diff",  diff1, 32'd0);
    chk("reset_flags", {29'd0, borrow1, ovf1, sig1}, 32'd0);
    chk("reset_state", {30'd0, st1}, 32'd0);
    chk("reset_diff4", diff4, 32'd0);
    rst_n = 1'b1;

    // table-driven vectors on the BPC=1 instance
    for (int i = 0; i < 9; i++) begin
      run_op(1, vecs[i].a, vecs[i].b, lat, bc);
      chk($sformatf("v%0d_latency", i), lat, 33);
      chk($sformatf("v%0d_busy_cycles", i), bc, 32);
      chk($sformatf("v%0d_diff", i), diff1, vecs[i].exp_diff);
      chk($sformatf("v%0d_borrow", i), {31'd0, borrow1}, {31'd0, vecs[i].exp_borrow});
      chk($sformatf("v%0d_overflow", i), {31'd0, ovf1}, {31'd0, vecs[i].exp_ovf});
      chk($sformatf("v%0d_sig", i), {31'd0, sig1}, 32'd1);
    end

    // results hold after done, done is a single-cycle pulse
    @(negedge clk);
    chk("hold_done_low", {31'd0, done1}, 32'd0);
    chk("hold_diff", diff1, 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_state_idle", {30'd0, st1}, 32'd0);

    // start during RUN is ignored; start in DONE runs back-to-back
    sel = 1;
    @(negedge clk);
    a1 = 32'd100; b1 = 32'd1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 100) begin
      if (lat == 10) begin a1 = 32'd5; b1 = 32'd5; start1 = 1'b1; end
      else start1 = 1'b0;
      @(negedge clk);
      lat++;
    end
    start1 = 1'b0;
    chk("ign_latency", lat, 33);
    chk("ign_diff", diff1, 32'd99);
    a1 = 32'd5; b1 = 32'd5; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("b2b_done_low", {31'd0, done1}, 32'd0);
    chk("b2b_busy", {31'd0, busy1}, 32'd1);
    chk("b2b_diff_cleared", diff1, 32'd0);
    lat = 1;
    while (!done1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_latency", lat, 33);
    chk("b2b_diff", diff1, 32'd0);
    chk("b2b_borrow", {31'd0, borrow1}, 32'd0);

    // reset mid-RUN abandons the operation
    @(negedge clk);
    a1 = 32'h5555_AAAA; b1 = 32'h1234_0000; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (11) @(negedge clk);
    chk("midrst_busy_before", {31'd0, busy1}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", {31'd0, busy1}, 32'd0);
    chk("midrst_diff", diff1, 32'd0);
    chk("midrst_state", {30'd0, st1}, 32'd0);
    bc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done1 || busy1) bc++;
    end
    chk("midrst_no_done", bc, 0);
    run_op(1, 32'd1, 32'd2, lat, bc);
    chk("after_rst_latency", lat, 33);
    chk("after_rst_diff", diff1, 32'hFFFF_FFFF);
    chk("after_rst_borrow", {31'd0, borrow1}, 32'd1);

    // BPC=4: done follows the start edge by 8 edges
    run_op(4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    chk("bpc4_latency", lat, 9);
    chk("bpc4_busy_cycles", bc, 8);
    chk("bpc4_diff", diff4, 32'd0);
    chk("bpc4_borrow", {31'd0, borrow4}, 32'd0);
    chk("bpc4_sig", {31'd0, sig4}, 32'd1);
    run_op(4, 32'd3, 32'd10, lat, bc);
    chk("bpc4_neg_diff", diff4, 32'hFFFF_FFF9);
    chk("bpc4_neg_borrow", {31'd0, borrow4}, 32'd1);

    // random operands on the BPC=4 instance
    for (int r = 0; r < 1000; r++) begin
      ra = $urandom();
      rb = $urandom();
      if (r % 8 == 0) rb = ra;
      run_op(4, ra, rb, lat, bc);
      chk("rnd_latency", lat, 9);
      chk("rnd_diff", diff4, ra - rb);
      chk("rnd_borrow", {31'd0, borrow4}, {31'd0, (ra < rb)});
      chk("rnd_sig", {31'd0, sig4}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_32b.md
Name: serial_subtractor_32b

Overview:
- Multi-cycle two's-complement subtractor computing diff = a - b, the inverse operation of the team's 32-bit ripple adder.
- Processes BPC bits per clock, LSB first, through a chain of 1-bit full-subtractor cells. Uses a start/busy/done handshake.
- Carries a built-in self-check flag `sig`: the serial result is compared against a behavioural a - b.
- Sits beside the adder as the ALU's low-area subtract path and as a bring-up checker.

Parameters:
- WIDTH, 32: operand and result width.
- BPC, 1: bits processed per cycle. Must divide WIDTH; legal values are 1, 2, 4, 8.
- STEPS, WIDTH/BPC: derived localparam, the number of RUN cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  minuend; captured on accepted start.
- b  in  WIDTH  subtrahend; captured on accepted start.
- busy  out  1  high while the operation is in progress.
- done  out  1  one-cycle pulse; results valid from this cycle.
- diff  out  WIDTH  a - b modulo 2^WIDTH.
- borrow  out  1  unsigned borrow, i.e. a < b as unsigned.
- overflow  out  1  signed overflow.
- sig  out  1  1 when diff equals the behavioural a - b on the latched operands.

Behaviour:
- Reset: when rst_n=0 at a clock edge, the state goes to IDLE. busy, done, diff, borrow, overflow, sig, the step counter and the operand registers all go to 0.
- Reset wins over every other event, including reset mid-RUN: the operation is abandoned and no done is produced.
- States:
  - IDLE: start=1 → RUN. Latch a and b into shift registers, carry=1 (subtract as a + ~b + 1), count=0, clear diff, busy=1.
  - RUN: each edge does the following.
    - Feed the low BPC bits of a_sh and ~b_sh through the BPC cells.
    - Shift the BPC result bits into diff from the MSB end.
    - Shift a_sh and b_sh right by BPC, update carry, increment count.
    - On the edge where count==STEPS-1, go to DONE: busy=0, done=1, and register borrow, overflow and sig.
  - DONE: done=1 for exactly one cycle.
    - start=1 → RUN, back-to-back, same actions as from IDLE, done=0.
    - Otherwise → IDLE.
- Latency: if start is sampled at edge E0, done is high in the cycle after edge E(STEPS). busy is high in the cycles after edges E0 through E(STEPS-1).
- start while in RUN is ignored. Operands are not re-sampled and the result reflects the originally captured operands.
- Outputs diff, borrow, overflow and sig hold their values from DONE until the next accepted start, where diff is cleared.
- borrow = ~final carry.
- overflow = (a_msb != b_msb) & (diff_msb != a_msb), using the latched MSBs.
- sig: compare the completed diff with (a_lat - b_lat)[WIDTH-1:0]. A separate copy of the operands is kept for this purpose. sig=1 on match, 0 otherwise.
- Inputs a and b may change freely after the accepting edge.

Decomposition:
- Package serial_sub_pkg:
  - state enum IDLE/RUN/DONE (2-bit);
  - DEFAULT_WIDTH=32;
  - legal-BPC check function used in an elaboration-time assertion.
- Sub-module full_sub_1b: 1-bit cell (x, y, cin → d, cout) implementing x + ~y + cin. Instantiate BPC of them in a generate chain inside the datapath.

Test Plan:
- WIDTH=32, BPC=1, a=10, b=3, start pulse: busy for 32 cycles, done in cycle 33 → diff=7, borrow=0, overflow=0, sig=1.
- a=3, b=10 → diff=0xFFFFFFF9, borrow=1, overflow=0, sig=1.
- a=0x80000000, b=1 → diff=0x7FFFFFFF, borrow=0, overflow=1. Then a=0x7FFFFFFF, b=0xFFFFFFFF → diff=0x80000000, overflow=1, borrow=1.
- Start a=100, b=1. Pulse start with a=5, b=5 at RUN cycle 10 → ignored; done at cycle 33 with diff=99. A start in the DONE cycle with a=5, b=5 → diff=0 after a further 32 cycles.
- rst_n=0 at RUN cycle 12 → next cycle busy=0, diff=0, and no done ever appears. Then start a=1, b=2 → diff=0xFFFFFFFF, borrow=1.
- BPC=4, a=0xFFFFFFFF, b=0xFFFFFFFF → done 8 cycles after start, diff=0, borrow=0. Random 1000 operand pairs → sig=1 on every done.
